// File: rtl/arith_unit.sv
// ============================================================================
// Module   : arith_unit
// Purpose  : A/B/C magnitude register datapath executing one-cycle micro-ops.
//            Optional sticky overflow flag is built when AU_OVERFLOW_TRAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        do_clear_a_to_au,
  input  logic        do_clear_b_to_au,
  input  logic        do_clear_c_to_au,
  input  logic        do_not_a_to_au,
  input  logic        do_not_b_to_au,
  input  logic        do_sum_to_au,
  input  logic        do_and_to_au,
  input  logic        do_set_c_30_to_au,
  input  logic        do_left_shift_b_to_au,
  input  logic        do_left_shift_c_to_au,
  input  logic        do_left_shift_c29_to_au,
  input  logic        do_right_shift_bc_to_au,
  input  logic        do_move_c_to_a_to_au,
  input  logic        do_move_c_to_b_to_au,
  input  logic        do_move_b_to_c_to_au,
  input  logic        do_read_mem_from_mem,
  input  logic [29:0] mem_read_data_from_mem,
  input  logic        do_arr_c_from_pnl,
  input  logic [29:0] arr_reg_c_from_pnl,
  input  logic        ser_in_from_io,
  output logic        carry_out_from_au,
  output logic        reg_c_1_from_au,
  output logic        reg_c_30_from_au,
  output logic        reg_b_0_from_au,
  output logic [29:0] mem_write_data_to_mem,
  output logic [3:0]  reg_c_to_io,
  output logic        au_overflow_to_op
);

  // Bit 1 is the MSB of every register; b[0] is the overflow bit above b[1].
  logic [1:30] a_q, a_d;
  logic [0:30] b_q, b_d;
  logic [1:30] c_q, c_d;
  logic        ocm_q, ocm_d;

  logic [30:0] raw_sum;
  logic [29:0] sum_w;
  logic        carry_w;
  logic        cin_w;

  assign raw_sum = {1'b0, a_q} + {1'b0, b_q[1:30]};
  assign carry_w = raw_sum[30];
  // End-around carry applies only in ones'-complement mode.
  assign cin_w   = ocm_q & carry_w;
  assign sum_w   = raw_sum[29:0] + {29'd0, cin_w};

  always_comb begin
    a_d = a_q;
    if (do_clear_a_to_au)          a_d = '0;
    else if (do_move_c_to_a_to_au) a_d = c_q;
    else if (do_not_a_to_au)       a_d = ~a_q;
  end

  always_comb begin
    b_d = b_q;
    if (do_move_c_to_b_to_au)         b_d = {1'b0, c_q};
    else if (do_clear_b_to_au)        b_d = '0;
    else if (do_sum_to_au)            b_d = {b_q[0] ^ carry_w, sum_w};
    else if (do_not_b_to_au)          b_d = {b_q[0], ~b_q[1:30]};
    else if (do_left_shift_b_to_au)   b_d = {b_q[1:30], c_q[1]};
    else if (do_right_shift_bc_to_au) b_d = {1'b0, b_q[0:29]};
  end

  always_comb begin
    c_d = c_q;
    if (do_move_b_to_c_to_au)         c_d = b_q[1:30];
    else if (do_and_to_au)            c_d = a_q & b_q[1:30];
    else if (do_clear_c_to_au)        c_d = '0;
    else if (do_right_shift_bc_to_au) c_d = {b_q[30], c_q[1:29]};
    else if (do_left_shift_c_to_au)
      // Serial input enters only on an io shift, not on a divide step.
      c_d = {c_q[2:30], do_left_shift_c29_to_au & ~do_left_shift_b_to_au & ser_in_from_io};
    else if (do_read_mem_from_mem)    c_d = mem_read_data_from_mem;
    else if (do_arr_c_from_pnl)       c_d = arr_reg_c_from_pnl;
    if (do_set_c_30_to_au)            c_d[30] = 1'b1;
  end

  always_comb begin
    ocm_d = ocm_q;
    if (do_clear_a_to_au || do_clear_b_to_au || do_move_c_to_a_to_au ||
        do_move_c_to_b_to_au || do_move_b_to_c_to_au)
      ocm_d = 1'b0;
    else if (do_not_a_to_au || do_not_b_to_au)
      ocm_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      ocm_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      ocm_q <= ocm_d;
    end
  end

`ifdef AU_OVERFLOW_TRAP_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (do_sum_to_au && !ocm_q && carry_w && b_q[0]) ovf_d = 1'b1;
    else if (do_clear_a_to_au)                       ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign au_overflow_to_op = ovf_q;
`else
  assign au_overflow_to_op = 1'b0;
`endif

  assign carry_out_from_au     = carry_w;
  assign reg_c_1_from_au       = c_q[1];
  assign reg_c_30_from_au      = c_q[30];
  assign reg_b_0_from_au       = b_q[0];
  assign mem_write_data_to_mem = c_q;
  assign reg_c_to_io           = c_q[1:4];

endmodule

`default_nettype wire

// File: doc/arith_unit.md
# arith_unit

Register datapath of the arithmetic unit: holds magnitude registers A, B and C and executes the single-cycle micro-operation pulses issued by the local program sequencer and by pu. It returns the carry and bit-probe levels that the sequencer branches on, and provides the C register to mem and io. Signs live in the sequencer; this block handles magnitudes only.

## Interface
- No parameters. Register magnitude is fixed at 30 bits, indexed [1:30] with bit 1 = MSB and bit 30 = LSB. B carries an extra overflow bit b[0].
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- do_clear_a_to_au, do_clear_b_to_au, do_clear_c_to_au, do_not_a_to_au, do_not_b_to_au, do_sum_to_au, do_and_to_au, do_set_c_30_to_au, do_left_shift_b_to_au, do_left_shift_c_to_au, do_left_shift_c29_to_au, do_right_shift_bc_to_au, do_move_c_to_a_to_au, do_move_c_to_b_to_au, do_move_b_to_c_to_au  in  1 each  one-cycle micro-op pulses
- do_read_mem_from_mem  in  1  level; load C from memory
- mem_read_data_from_mem  in  30  memory word magnitude
- do_arr_c_from_pnl  in  1  level; load C from panel
- arr_reg_c_from_pnl  in  30  panel switch value
- ser_in_from_io  in  1  serial input bit for io shifting
- carry_out_from_au  out  1  combinational carry out of a[1:30]+b[1:30]
- reg_c_1_from_au, reg_c_30_from_au, reg_b_0_from_au  out  1 each  direct register bits
- mem_write_data_to_mem  out  30  c[1:30]
- reg_c_to_io  out  4  c[1:4]
- au_overflow_to_op  out  1  sticky overflow flag (see Configuration)

## Operation
- Internal flag ocm (ones'-complement mode):
  - Set by do_not_a or do_not_b.
  - Cleared by do_clear_a, do_clear_b, do_move_c_to_a, do_move_c_to_b, do_move_b_to_c.
- A update priority: clear_a (A<=0) > move_c_to_a (A<=C) > not_a (A<=~A).
- B update priority:
  - move_c_to_b: b[1:30]<=C, b[0]<=0.
  - clear_b: B<=0.
  - sum: b[1:30] <= (a+b+cin) mod 2^30, where cin = ocm & carry_out; b[0] <= b[0]^carry_out.
  - not_b: b[1:30] <= ~b[1:30]; b[0] unchanged.
  - left_shift_b: b[0:29]<=b[1:30], b[30]<=c[1].
  - right_shift_bc: b[0]<=0, b[1:30]<=b[0:29].
- C updates, highest priority first:
  - move_b_to_c: C<=b[1:30].
  - and: C<=A&b[1:30].
  - clear_c: C<=0.
  - right_shift_bc: c[1:30] <= {b[30], c[1:29]}, using pre-shift b[30].
  - left_shift_c: c[1:29]<=c[2:30]; c[30] <= ser_in if left_shift_c29 & !left_shift_b, else 0.
  - read_mem: C<=mem_read_data.
  - arr_c: C<=arr_reg_c.
- set_c_30 ORs 1 into c[30] after the update above, in the same cycle.
- Concurrent pulses on different registers all take effect in the same cycle, each computed from pre-edge values.
- Pulse combinations the sequencer generates, all required to work:
  - not_a + not_b
  - sum + set_c_30
  - left_shift_b + left_shift_c + left_shift_c29
  - right_shift_bc alone
- Arithmetic semantics:
  - Subtraction B−A uses ones'-complement form with end-around carry.
  - Multiply accumulates carries into b[0]; the next right shift moves b[0] into b[1].

## Timing
- All register updates occur on the posedge following the pulse. Every micro-op is 1 cycle, with no handshake and no busy state.
- carry_out is combinational from current A and B; it is valid in the same cycle the sequencer samples it.
- Reset state: A=0, B=0 (b[0]=0), C=0, ocm=0, overflow=0.
  - Resulting outputs: carry_out=0, reg_c_1=0, reg_c_30=0, reg_b_0=0, mem_write_data=0, reg_c_to_io=0, au_overflow=0.
- Reset asserted mid-sequence clears all state immediately, asynchronously. The first pulse after release acts on the zeroed registers.
- Wrap: sum without ocm drops bit 2^31 (b[0] toggles); this is not an error.

## Configuration
- AU_OVERFLOW_TRAP_EN defined:
  - au_overflow_to_op sets on any do_sum cycle where ocm=0 and carry_out=1 and b[0]=1 before the edge.
  - It stays set until do_clear_a or reset.
- AU_OVERFLOW_TRAP_EN undefined: au_overflow_to_op is tied 0 and no flag register is built.

## Test plan
- Sum: A=0x0000_0005, B=3, pulse do_sum -> B=8, b[0]=0. Then A=0x3FFF_FFFF, B=1: carry_out=1 before the edge; after do_sum, B=0 and b[0]=1.
- Subtract: B=7, A=5, pulse do_not_a -> ocm=1; carry_out=1; do_sum -> B=2 (end-around carry).
- Multiply step: B=0, C=1, A=3, pulse do_sum then do_right_shift_bc -> B=1, c[1]=1, c[30]=0.
- Divide step: B=0x2000_0000, C=0x2000_0000, pulse left_shift_b + left_shift_c + left_shift_c29 -> b[0]=1, b[30]=1, C=0x0000_0000 with c[30]=0. Then do_sum + do_set_c_30 -> c[30]=1.
- IO: ser_in=1, pulse left_shift_c + left_shift_c29 four times from C=0 -> C=0xF, reg_c_to_io=0.
- Reset: assert resetn low mid-multiply with B≠0 -> all outputs 0 asynchronously. With AU_OVERFLOW_TRAP_EN, overflow set by B=0x3FFF_FFFF|b0=1, A=1, do_sum stays 1 until do_clear_a.
